lcd_spi_rx: RTL and testbench

- Receive-side decoder for the serial LCD link that the scalescreen driver emits on sda/scl/cs/rs.
- Oversamples the link on the system clock, deserialises bytes, and tracks the controller's CASET/RASET/RAMWR command set.
- Emits decoded RGB565 pixels with screen coordinates.
- Serves as the bench-side display model and as the front end of a mirrored second display.

---
 rtl/lcd_spi_rx.sv | 293 +++++++++++++++++++++++++++++
 tb/tb_lcd_spi_rx.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/lcd_spi_rx.sv
// lcd_spi_rx: receive-side decoder for the sda/scl/cs/rs serial LCD link.
// Oversamples the link, deserialises bytes, tracks CASET/RASET/RAMWR, emits RGB565 pixels.
//
// Ports:
//   clk, reset          system clock, async active-high reset
//   scl, sda, cs, rs    raw serial link (cs active-low, rs 1 = data byte)
//   byte_valid/byte_out/byte_is_data   completed byte and its rs value
//   pix_valid/pix_r/pix_g/pix_b/pix_x/pix_y   decoded pixel and screen position
//   frame_start         pulse when RAMWR is accepted
//   framing_err         pulse when cs rises on a partial byte
module lcd_spi_rx #(
  parameter int WIDTH  = 160,
  parameter int HEIGHT = 128
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       scl,
  input  logic       sda,
  input  logic       cs,
  input  logic       rs,
  output logic       byte_valid,
  output logic [7:0] byte_out,
  output logic       byte_is_data,
  output logic       pix_valid,
  output logic [4:0] pix_r,
  output logic [5:0] pix_g,
  output logic [4:0] pix_b,
  output logic [7:0] pix_x,
  output logic [6:0] pix_y,
  output logic       frame_start,
  output logic       framing_err
);

  typedef enum logic [2:0] {
    IDLE, CASET, RASET, RAMWR_HI, RAMWR_LO
  } state_t;

  // Two-flop synchronisers
  logic [1:0] scl_s_q, scl_s_d;
  logic [1:0] sda_s_q, sda_s_d;
  logic [1:0] rs_s_q, rs_s_d;
  logic [1:0] cs_s_q, cs_s_d;
  logic       scl_p_q, scl_p_d;

  // Registered edge stage: edge flag plus the synced
  // inputs that belong to it, kept aligned.
  logic rise_q, rise_d;
  logic sda_e_q, sda_e_d;
  logic rs_e_q, rs_e_d;
  logic cs_e_q, cs_e_d;

  logic [7:0] shift_q, shift_d;
  logic [2:0] cnt_q, cnt_d;
  logic       byte_valid_q, byte_valid_d;
  logic [7:0] byte_out_q, byte_out_d;
  logic       byte_is_data_q, byte_is_data_d;
  logic       framing_err_q, framing_err_d;

  state_t     state_q, state_d;
  logic [1:0] pidx_q, pidx_d;
  logic [7:0] par_q, par_d;
  logic [7:0] hi_q, hi_d;
  logic [7:0] xs_q, xs_d, xe_q, xe_d;
  logic [6:0] ys_q, ys_d, ye_q, ye_d;
  logic [7:0] cx_q, cx_d;
  logic [6:0] cy_q, cy_d;

  logic       pix_valid_q, pix_valid_d;
  logic [4:0] pix_r_q, pix_r_d;
  logic [5:0] pix_g_q, pix_g_d;
  logic [4:0] pix_b_q, pix_b_d;
  logic [7:0] pix_x_q, pix_x_d;
  logic [6:0] pix_y_q, pix_y_d;
  logic       frame_start_q, frame_start_d;

  logic ev;
  logic is_cmd;

  assign ev     = byte_valid_q;
  assign is_cmd = ~byte_is_data_q;

  // Front end: sync, edge detect, shift register
  always_comb begin
    scl_s_d = {scl_s_q[0], scl};
    sda_s_d = {sda_s_q[0], sda};
    rs_s_d  = {rs_s_q[0], rs};
    cs_s_d  = {cs_s_q[0], cs};
    scl_p_d = scl_s_q[1];
    rise_d  = scl_s_q[1] & ~scl_p_q;
    sda_e_d = sda_s_q[1];
    rs_e_d  = rs_s_q[1];
    cs_e_d  = cs_s_q[1];

    shift_d        = shift_q;
    cnt_d          = cnt_q;
    byte_valid_d   = 1'b0;
    byte_out_d     = byte_out_q;
    byte_is_data_d = byte_is_data_q;
    framing_err_d  = 1'b0;

    // Deselect wins over a coincident scl edge
    if (cs_e_q) begin
      cnt_d         = 3'd0;
      framing_err_d = (cnt_q != 3'd0);
    end else if (rise_q) begin
      shift_d = {shift_q[6:0], sda_e_q};
      cnt_d   = cnt_q + 3'd1;
      if (cnt_q == 3'd7) begin
        byte_valid_d   = 1'b1;
        byte_out_d     = {shift_q[6:0], sda_e_q};
        byte_is_data_d = rs_e_q;
      end
    end
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      pidx_q  <= 2'd0;
    end else begin
      state_q <= state_d;
      pidx_q  <= pidx_d;
    end
  end

  // Next-state logic, one step per completed byte
  always_comb begin
    state_d = state_q;
    pidx_d  = pidx_q;
    if (ev) begin
      if (is_cmd) begin
        pidx_d = 2'd0;
        unique case (1'b1)
          byte_out_q == 8'h2A: state_d = CASET;
          byte_out_q == 8'h2B: state_d = RASET;
          byte_out_q == 8'h2C: state_d = RAMWR_HI;
          default:             state_d = IDLE;
        endcase
      end else begin
        case (state_q)
          CASET, RASET: begin
            pidx_d = pidx_q + 2'd1;
            if (pidx_q == 2'd3) state_d = IDLE;
          end
          RAMWR_HI: state_d = RAMWR_LO;
          RAMWR_LO: state_d = RAMWR_HI;
          default:  state_d = state_q;
        endcase
      end
    end
  end

  // Outputs, window and cursor
  always_comb begin
    par_d         = par_q;
    hi_d          = hi_q;
    xs_d          = xs_q;
    xe_d          = xe_q;
    ys_d          = ys_q;
    ye_d          = ye_q;
    cx_d          = cx_q;
    cy_d          = cy_q;
    pix_valid_d   = 1'b0;
    pix_r_d       = pix_r_q;
    pix_g_d       = pix_g_q;
    pix_b_d       = pix_b_q;
    pix_x_d       = pix_x_q;
    pix_y_d       = pix_y_q;
    frame_start_d = 1'b0;

    if (ev && is_cmd && byte_out_q == 8'h2C) begin
      cx_d          = xs_q;
      cy_d          = ys_q;
      frame_start_d = 1'b1;
    end

    if (ev && !is_cmd) begin
      case (state_q)
        CASET: begin
          if (pidx_q == 2'd1) par_d = byte_out_q;
          if (pidx_q == 2'd3) begin
            xs_d = par_q;
            xe_d = byte_out_q;
          end
        end
        RASET: begin
          if (pidx_q == 2'd1) par_d = byte_out_q;
          if (pidx_q == 2'd3) begin
            ys_d = par_q[6:0];
            ye_d = byte_out_q[6:0];
          end
        end
        RAMWR_HI: hi_d = byte_out_q;
        RAMWR_LO: begin
          pix_valid_d = 1'b1;
          pix_r_d     = hi_q[7:3];
          pix_g_d     = {hi_q[2:0], byte_out_q[7:5]};
          pix_b_d     = byte_out_q[4:0];
          pix_x_d     = cx_q;
          pix_y_d     = cy_q;
          // Only equality ends a row, so xs>xe runs until wrap
          if (cx_q == xe_q) begin
            cx_d = xs_q;
            cy_d = (cy_q == ye_q) ? ys_q : cy_q + 7'd1;
          end else begin
            cx_d = cx_q + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      scl_s_q        <= 2'b00;
      sda_s_q        <= 2'b00;
      rs_s_q         <= 2'b00;
      cs_s_q         <= 2'b11;
      scl_p_q        <= 1'b0;
      rise_q         <= 1'b0;
      sda_e_q        <= 1'b0;
      rs_e_q         <= 1'b0;
      cs_e_q         <= 1'b1;
      shift_q        <= 8'd0;
      cnt_q          <= 3'd0;
      byte_valid_q   <= 1'b0;
      byte_out_q     <= 8'd0;
      byte_is_data_q <= 1'b0;
      framing_err_q  <= 1'b0;
      par_q          <= 8'd0;
      hi_q           <= 8'd0;
      xs_q           <= 8'd0;
      xe_q           <= 8'(WIDTH - 1);
      ys_q           <= 7'd0;
      ye_q           <= 7'(HEIGHT - 1);
      cx_q           <= 8'd0;
      cy_q           <= 7'd0;
      pix_valid_q    <= 1'b0;
      pix_r_q        <= 5'd0;
      pix_g_q        <= 6'd0;
      pix_b_q        <= 5'd0;
      pix_x_q        <= 8'd0;
      pix_y_q        <= 7'd0;
      frame_start_q  <= 1'b0;
    end else begin
      scl_s_q        <= scl_s_d;
      sda_s_q        <= sda_s_d;
      rs_s_q         <= rs_s_d;
      cs_s_q         <= cs_s_d;
      scl_p_q        <= scl_p_d;
      rise_q         <= rise_d;
      sda_e_q        <= sda_e_d;
      rs_e_q         <= rs_e_d;
      cs_e_q         <= cs_e_d;
      shift_q        <= shift_d;
      cnt_q          <= cnt_d;
      byte_valid_q   <= byte_valid_d;
      byte_out_q     <= byte_out_d;
      byte_is_data_q <= byte_is_data_d;
      framing_err_q  <= framing_err_d;
      par_q          <= par_d;
      hi_q           <= hi_d;
      xs_q           <= xs_d;
      xe_q           <= xe_d;
      ys_q           <= ys_d;
      ye_q           <= ye_d;
      cx_q           <= cx_d;
      cy_q           <= cy_d;
      pix_valid_q    <= pix_valid_d;
      pix_r_q        <= pix_r_d;
      pix_g_q        <= pix_g_d;
      pix_b_q        <= pix_b_d;
      pix_x_q        <= pix_x_d;
      pix_y_q        <= pix_y_d;
      frame_start_q  <= frame_start_d;
    end
  end

  assign byte_valid   = byte_valid_q;
  assign byte_out     = byte_out_q;
  assign byte_is_data = byte_is_data_q;
  assign pix_valid    = pix_valid_q;
  assign pix_r        = pix_r_q;
  assign pix_g        = pix_g_q;
  assign pix_b        = pix_b_q;
  assign pix_x        = pix_x_q;
  assign pix_y        = pix_y_q;
  assign frame_start  = frame_start_q;
  assign framing_err  = framing_err_q;

endmodule

// File: tb/tb_lcd_spi_rx.sv
// tb_lcd_spi_rx: directed bench for lcd_spi_rx.
// Drives the serial link at clk/8 and checks bytes, pixels and pulses.
module tb_lcd_spi_rx;

  logic       clk = 1'b0;
  logic       reset;
  logic       scl, sda, cs, rs;
  logic       byte_valid;
  logic [7:0] byte_out;
  logic       byte_is_data;
  logic       pix_valid;
  logic [4:0] pix_r;
  logic [5:0] pix_g;
  logic [4:0] pix_b;
  logic [7:0] pix_x;
  logic [6:0] pix_y;
  logic       frame_start;
  logic       framing_err;

  lcd_spi_rx #(.WIDTH(160), .HEIGHT(128)) dut (
    .clk(clk), .reset(reset),
    .scl(scl), .sda(sda), .cs(cs), .rs(rs),
    .byte_valid(byte_valid), .byte_out(byte_out),
    .byte_is_data(byte_is_data),
    .pix_valid(pix_valid),
    .pix_r(pix_r), .pix_g(pix_g), .pix_b(pix_b),
    .pix_x(pix_x), .pix_y(pix_y),
    .frame_start(frame_start),
    .framing_err(framing_err)
  );

  always #5 clk = ~clk;

  int ntests = 0;
  int nfail  = 0;
  int cyc    = 0;
  int rise_cyc = 0;
  int bv_cyc = 0;
  int bv_cnt = 0;
  int fs_cnt = 0;
  int fe_cnt = 0;
  int pix_cnt = 0;
  logic [14:0] px_xy  [0:31];
  logic [15:0] px_rgb [0:31];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (byte_valid) begin
      bv_cnt = bv_cnt + 1;
      bv_cyc = cyc;
    end
    if (frame_start) fs_cnt = fs_cnt + 1;
    if (framing_err) fe_cnt = fe_cnt + 1;
    if (pix_valid) begin
      if (pix_cnt < 32) begin
        px_xy[pix_cnt]  = {pix_x, pix_y};
        px_rgb[pix_cnt] = {pix_r, pix_g, pix_b};
      end
      pix_cnt = pix_cnt + 1;
    end
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; sda changes while scl is low
  task automatic send_bit(input logic b, input logic r);
    sda = b;
    rs  = r;
    repeat (4) @(negedge clk);
    scl = 1'b1;
    rise_cyc = cyc;
    repeat (4) @(negedge clk);
    scl = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic r);
    for (int i = 7; i >= 0; i--) send_bit(b[i], r);
    repeat (8) @(negedge clk);
  endtask

  task automatic send_pix(input logic [15:0] p);
    send_byte(p[15:8], 1'b1);
    send_byte(p[7:0], 1'b1);
  endtask

  int pc;
  int fc;
  int bc;

  initial begin
    reset = 1'b1;
    scl = 1'b0; sda = 1'b0; cs = 1'b1; rs = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_bytes", {byte_valid, byte_out, byte_is_data}, 0);
    chk("rst_pix", {pix_valid, pix_r, pix_g, pix_b, pix_x, pix_y}, 0);
    chk("rst_pulses", {frame_start, framing_err}, 0);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    cs = 1'b0;
    repeat (4) @(negedge clk);

    // Byte capture and latency
    send_byte(8'hA5, 1'b1);
    chk("cap_count", bv_cnt, 1);
    chk("cap_byte", byte_out, 8'hA5);
    chk("cap_isdata", byte_is_data, 1);
    chk("cap_latency", bv_cyc - rise_cyc, 4);

    // Framing error on a 5-bit fragment
    for (int i = 0; i < 5; i++) send_bit(1'b1, 1'b1);
    repeat (4) @(negedge clk);
    cs = 1'b1;
    repeat (10) @(negedge clk);
    cs = 1'b0;
    repeat (4) @(negedge clk);
    chk("frm_err_count", fe_cnt, 1);
    chk("frm_no_byte", bv_cnt, 1);
    send_byte(8'h3C, 1'b1);
    chk("frm_next_count", bv_cnt, 2);
    chk("frm_next_byte", byte_out, 8'h3C);

    // Default window, two pixels
    send_byte(8'h2C, 1'b0);
    chk("cmd_byte", byte_out, 8'h2C);
    chk("cmd_isdata", byte_is_data, 0);
    chk("dflt_fs", fs_cnt, 1);
    send_pix(16'hF800);
    send_pix(16'h07E0);
    chk("dflt_pixcnt", pix_cnt, 2);
    chk("dflt_p0_xy", px_xy[0], {8'd0, 7'd0});
    chk("dflt_p0_r", px_rgb[0][15:11], 31);
    chk("dflt_p0_gb", px_rgb[0][10:0], 0);
    chk("dflt_p1_xy", px_xy[1], {8'd1, 7'd0});
    chk("dflt_p1_rgb", px_rgb[1], {5'd0, 6'd63, 5'd0});
    chk("dflt_fs_once", fs_cnt, 1);

    // Window wrap: x 10..11, y 5..6
    send_byte(8'h2A, 1'b0);
    send_byte(8'h00, 1'b1); send_byte(8'h0A, 1'b1);
    send_byte(8'h00, 1'b1); send_byte(8'h0B, 1'b1);
    send_byte(8'h2B, 1'b0);
    send_byte(8'h00, 1'b1); send_byte(8'h05, 1'b1);
    send_byte(8'h00, 1'b1); send_byte(8'h06, 1'b1);
    send_byte(8'h2C, 1'b0);
    chk("win_fs", fs_cnt, 2);
    send_pix(16'h1234);
    send_pix(16'h0001);
    send_pix(16'h0002);
    send_pix(16'h0003);
    send_pix(16'h0004);
    chk("win_pixcnt", pix_cnt, 7);
    chk("win_p0_xy", px_xy[2], {8'd10, 7'd5});
    chk("win_p0_rgb", px_rgb[2], {5'd2, 6'd17, 5'd20});
    chk("win_p1_xy", px_xy[3], {8'd11, 7'd5});
    chk("win_p2_xy", px_xy[4], {8'd10, 7'd6});
    chk("win_p3_xy", px_xy[5], {8'd11, 7'd6});
    chk("win_p4_xy", px_xy[6], {8'd10, 7'd5});
    chk("win_hold_x", pix_x, 10);
    chk("win_hold_b", pix_b, 4);

    // Reset between high and low byte
    send_byte(8'hFF, 1'b1);
    reset = 1'b1;
    #1;
    chk("mid_rst_bytes", {byte_valid, byte_out, byte_is_data}, 0);
    chk("mid_rst_pix", {pix_valid, pix_r, pix_g, pix_b, pix_x, pix_y}, 0);
    @(negedge clk);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    pc = pix_cnt;
    bc = bv_cnt;
    send_byte(8'hFF, 1'b1);
    chk("mid_rst_byte_ok", bv_cnt, bc + 1);
    chk("mid_rst_nopix", pix_cnt, pc);
    chk("mid_rst_hold", {pix_x, pix_y}, 0);

    // Aborted CASET leaves the window at reset values
    fc = fs_cnt;
    send_byte(8'h2A, 1'b0);
    send_byte(8'h00, 1'b1); send_byte(8'h14, 1'b1);
    send_byte(8'h2C, 1'b0);
    chk("abort_fs", fs_cnt, fc + 1);
    send_pix(16'hFFFF);
    chk("abort_pixcnt", pix_cnt, pc + 1);
    chk("abort_xy", {pix_x, pix_y}, {8'd0, 7'd0});
    chk("abort_rgb", {pix_r, pix_g, pix_b}, {5'd31, 6'd63, 5'd31});
    send_pix(16'h0000);
    chk("abort_p1_xy", {pix_x, pix_y}, {8'd1, 7'd0});

    // Unknown command returns to idle; data then ignored
    pc = pix_cnt;
    send_byte(8'h00, 1'b0);
    send_byte(8'h55, 1'b1);
    send_byte(8'h66, 1'b1);
    chk("idle_nopix", pix_cnt, pc);
    chk("idle_byte", byte_out, 8'h66);
    chk("no_extra_ferr", fe_cnt, 1);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
